// File: rtl/lut_wvf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_wvf_pkg : shared encodings for the multi-channel LUT synthesiser |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package lut_wvf_pkg;

  localparam logic [1:0] MODE_CONT    = 2'b00;
  localparam logic [1:0] MODE_ONESHOT = 2'b01;
  localparam logic [1:0] MODE_BURST   = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lut_wvf_gen_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_wvf_gen_multi_if : config/data bundle of the LUT synthesiser     |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
interface lut_wvf_gen_multi_if
  import lut_wvf_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int LUT_WIDTH   = 21,
  parameter int NUM_CH      = 2,
  parameter int PRESC_WIDTH = 12,
  parameter int BURST_WIDTH = 8
);
  localparam int IDX_W = idx_width(LUT_WIDTH);

  logic                             en;
  logic [PRESC_WIDTH-1:0]           presc;
  logic [BIT_WIDTH*LUT_WIDTH-1:0]   lut_rom;
  logic [2*NUM_CH-1:0]              mode;
  logic [BURST_WIDTH*NUM_CH-1:0]    burst_cnt;
  logic [IDX_W*NUM_CH-1:0]          phase_ofs;
  logic [NUM_CH-1:0]                start;
  logic [NUM_CH-1:0]                stop;
  logic [BIT_WIDTH*NUM_CH-1:0]      lut_value;
  logic [NUM_CH-1:0]                valid;
  logic [NUM_CH-1:0]                lut_end;
  logic [NUM_CH-1:0]                busy;
  logic [NUM_CH-1:0]                done;

  modport master (
    output en, presc, lut_rom, mode, burst_cnt, phase_ofs, start, stop,
    input  lut_value, valid, lut_end, busy, done
  );

  modport slave (
    input  en, presc, lut_rom, mode, burst_cnt, phase_ofs, start, stop,
    output lut_value, valid, lut_end, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/lut_wvf_ch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_wvf_ch : one synthesiser channel (FSM, index, period count, mux) |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module lut_wvf_ch
  import lut_wvf_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int LUT_WIDTH   = 21,
  parameter int BURST_WIDTH = 8,
  parameter int WRAP_IDX    = 1,
  parameter int IDX_W       = idx_width(LUT_WIDTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic                           tick_i,
  input  logic [BIT_WIDTH*LUT_WIDTH-1:0] lut_rom_i,
  input  logic [1:0]                     mode_i,
  input  logic [BURST_WIDTH-1:0]         burst_cnt_i,
  input  logic [IDX_W-1:0]               phase_ofs_i,
  input  logic                           start_i,
  input  logic                           stop_i,
  output logic [BIT_WIDTH-1:0]           lut_value_o,
  output logic                           valid_o,
  output logic                           lut_end_o,
  output logic                           busy_o,
  output logic                           done_o
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_WIDTH - 1);
  localparam logic [IDX_W-1:0] WRAP     = IDX_W'(WRAP_IDX);

  ch_state_e              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   cont_q, cont_d;
  logic [BURST_WIDTH-1:0] per_q, per_d;
  logic [BIT_WIDTH-1:0]   value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   end_q, end_d;
  logic                   done_q, done_d;
  logic [BIT_WIDTH-1:0]   sample;

  assign sample = lut_rom_i[idx_q*BIT_WIDTH +: BIT_WIDTH];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cont_d  = cont_q;
    per_d   = per_q;
    value_d = value_q;
    valid_d = 1'b0;
    end_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_i && start_i && !stop_i) begin
          state_d = ST_RUN;
          idx_d   = (phase_ofs_i > LAST_IDX) ? '0 : phase_ofs_i;
          cont_d  = (mode_i == MODE_CONT);
          // Reserved mode 11 falls through to a single period like one-shot
          if (mode_i != MODE_BURST)
            per_d = BURST_WIDTH'(1);
          else
            per_d = (burst_cnt_i == '0) ? BURST_WIDTH'(1) : burst_cnt_i;
        end
      end
      ST_RUN: begin
        if (!en_i || stop_i) begin
          state_d = ST_IDLE;
        end else if (tick_i) begin
          value_d = sample;
          valid_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            end_d = 1'b1;
            idx_d = WRAP;
            if (!cont_q) begin
              per_d = per_q - 1'b1;
              if (per_q == BURST_WIDTH'(1)) begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cont_q  <= 1'b0;
      per_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cont_q  <= cont_d;
      per_q   <= per_d;
      value_q <= value_d;
      valid_q <= valid_d;
      end_q   <= end_d;
      done_q  <= done_d;
    end
  end

  assign lut_value_o = value_q;
  assign valid_o     = valid_q;
  assign lut_end_o   = end_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: rtl/lut_wvf_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lut_wvf_gen_multi : NUM_CH-channel LUT DDS with shared prescaler     |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module lut_wvf_gen_multi
  import lut_wvf_pkg::*;
#(
  parameter int BIT_WIDTH   = 16,
  parameter int LUT_WIDTH   = 21,
  parameter int NUM_CH      = 2,
  parameter int PRESC_WIDTH = 12,
  parameter int BURST_WIDTH = 8,
  parameter int WRAP_IDX    = 1
) (
  input  logic                clk_sys_i,
  input  logic                rst_i,
  lut_wvf_gen_multi_if.slave  bus
);
  localparam int IDX_W = idx_width(LUT_WIDTH);

  logic [PRESC_WIDTH-1:0]      presc_cnt_q, presc_cnt_d;
  logic [PRESC_WIDTH-1:0]      presc_lim_q, presc_lim_d;
  logic                        tick;
  logic [BIT_WIDTH*NUM_CH-1:0] lut_value_w;
  logic [NUM_CH-1:0]           valid_w, lut_end_w, busy_w, done_w;

  // The limit is only reloaded at a wrap (or while disabled) so a new
  // PRESC never truncates the period in flight.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    presc_lim_d = presc_lim_q;
    tick        = 1'b0;
    if (!bus.en) begin
      presc_cnt_d = '0;
      presc_lim_d = bus.presc;
    end else if (presc_cnt_q == presc_lim_q) begin
      tick        = 1'b1;
      presc_cnt_d = '0;
      presc_lim_d = bus.presc;
    end else begin
      presc_cnt_d = presc_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_i) begin
    if (rst_i) begin
      presc_cnt_q <= '0;
      presc_lim_q <= '0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      presc_lim_q <= presc_lim_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lut_wvf_ch #(
      .BIT_WIDTH   (BIT_WIDTH),
      .LUT_WIDTH   (LUT_WIDTH),
      .BURST_WIDTH (BURST_WIDTH),
      .WRAP_IDX    (WRAP_IDX),
      .IDX_W       (IDX_W)
    ) u_ch (
      .clk_i       (clk_sys_i),
      .rst_i       (rst_i),
      .en_i        (bus.en),
      .tick_i      (tick),
      .lut_rom_i   (bus.lut_rom),
      .mode_i      (bus.mode[g*2 +: 2]),
      .burst_cnt_i (bus.burst_cnt[g*BURST_WIDTH +: BURST_WIDTH]),
      .phase_ofs_i (bus.phase_ofs[g*IDX_W +: IDX_W]),
      .start_i     (bus.start[g]),
      .stop_i      (bus.stop[g]),
      .lut_value_o (lut_value_w[g*BIT_WIDTH +: BIT_WIDTH]),
      .valid_o     (valid_w[g]),
      .lut_end_o   (lut_end_w[g]),
      .busy_o      (busy_w[g]),
      .done_o      (done_w[g])
    );
  end

  assign bus.lut_value = lut_value_w;
  assign bus.valid     = valid_w;
  assign bus.lut_end   = lut_end_w;
  assign bus.busy      = busy_w;
  assign bus.done      = done_w;

endmodule
`default_nettype wire

// File: doc/lut_wvf_gen_multi.md
Name: lut_wvf_gen_multi

Overview:
Multi-channel direct digital synthesiser that replays one waveform LUT on NUM_CH independent channels.
- LUT contents arrive on a flat bus, so the block has no embedded table.
- Each channel has its own phase offset, start/stop control, and run mode (continuous, one-shot or burst).
- All channels share one programmable sample-rate prescaler.
- Sits between the config middleware (register bank) and the DAC serialisers.

Parameters:
BIT_WIDTH, 16, bit width of one LUT sample.
LUT_WIDTH, 21, number of LUT entries.
NUM_CH, 2, number of output channels.
PRESC_WIDTH, 12, width of the runtime prescaler value.
BURST_WIDTH, 8, width of the burst period count.
WRAP_IDX, 1, index loaded after index LUT_WIDTH-1. Value 1 skips the duplicated start sample.

Ports:
CLK_SYS  in  1  system clock.
RST  in  1  asynchronous, active-high reset.
EN  in  1  global enable. Low forces all channels IDLE and clears the prescaler.
PRESC  in  PRESC_WIDTH  sample period is PRESC+1 clock cycles.
LUT_ROM  in  BIT_WIDTH*LUT_WIDTH  LUT data; entry i is at [i*BIT_WIDTH +: BIT_WIDTH].
MODE  in  2*NUM_CH  per-channel mode: 00 continuous, 01 one-shot, 10 burst, 11 reserved (treated as one-shot).
BURST_CNT  in  BURST_WIDTH*NUM_CH  per-channel number of periods in burst mode.
PHASE_OFS  in  IDX_W*NUM_CH  per-channel start index; IDX_W = $clog2(LUT_WIDTH).
START  in  NUM_CH  per-channel start request (level, sampled each cycle).
STOP  in  NUM_CH  per-channel abort request.
LUT_VALUE  out  BIT_WIDTH*NUM_CH  registered sample per channel.
VALID  out  NUM_CH  one-cycle strobe when LUT_VALUE updates.
LUT_END  out  NUM_CH  one-cycle strobe with VALID when the emitted sample index is LUT_WIDTH-1.
BUSY  out  NUM_CH  channel is in RUN.
DONE  out  NUM_CH  one-cycle strobe on natural completion.

Behaviour:
- **Reset** (RST=1, asynchronous): all outputs 0, channels IDLE, prescaler 0.
- **Prescaler:**
  - Counts 0..PRESC while EN=1; tick is asserted in the cycle where count==PRESC, then count wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - A PRESC change takes effect at the next wrap.
- **Channel FSM:** states IDLE and RUN.
- **IDLE -> RUN** on START=1 (while EN=1 and STOP=0):
  - idx <= PHASE_OFS; a PHASE_OFS >= LUT_WIDTH is clamped to 0.
  - MODE and BURST_CNT are latched; BURST_CNT=0 is treated as 1.
  - BUSY=1 from the next cycle.
- **In RUN, on tick:**
  - LUT_VALUE <= LUT_ROM entry idx, and VALID=1 in the following cycle (1-cycle latency from tick).
  - If idx==LUT_WIDTH-1: LUT_END=1, idx <= WRAP_IDX, period counter decrements. Otherwise idx <= idx+1.
- **Completion:**
  - One-shot: completes after the first sample at index LUT_WIDTH-1.
  - Burst: completes after BURST_CNT such samples.
  - Continuous: never completes.
  - On completion, DONE pulses in the same cycle as the final VALID/LUT_END, the channel returns to IDLE, and BUSY drops that cycle.
- **STOP in RUN:** IDLE next cycle, no DONE, no further VALID.
- **Simultaneous events:**
  - START together with STOP: STOP wins.
  - START while in RUN: ignored.
  - START held high after DONE: restarts in the next cycle.
- **EN=0:** all channels go IDLE within 1 cycle with no DONE, and VALID/LUT_END/DONE stay 0.
- **Holding:** LUT_VALUE always holds its last value when not updated, including across STOP and EN=0; only RST clears it.
- **Channel independence:** channels share the tick only, so samples from all running channels update in the same cycle.

Decomposition:
- Package lut_wvf_pkg:
  - MODE_CONT/MODE_ONESHOT/MODE_BURST encodings.
  - FSM state encoding.
  - Index-width helper function.
- Sub-module lut_wvf_ch: one channel's FSM, index and period counter, and sample mux from LUT_ROM. It is instantiated NUM_CH times via generate.
- The prescaler lives in the top level.

Test Plan:
Use the default LUT of 21 sine samples: index 0=32768, 1=42893, 5=65535, 15=0, 20=32767.
1. Continuous: PRESC=3, ch0 MODE=00, PHASE_OFS=0, START -> VALID every 4 cycles with values 32768, 42893, ..., 32767 (LUT_END=1), then 42893 (wrap to index 1); BUSY stays 1.
2. One-shot: ch0 MODE=01 -> exactly 21 VALIDs; the last is 32767 with LUT_END=DONE=1 in the same cycle; BUSY=0 afterwards.
3. Burst: BURST_CNT=3, PRESC=0 -> 21+20+20=61 consecutive VALIDs, a single DONE on the 61st; BURST_CNT=0 behaves as one-shot.
4. Multi-channel: ch0 PHASE_OFS=0 and ch1 PHASE_OFS=5 started in the same cycle -> first VALIDs coincide with ch0=32768 and ch1=65535; PHASE_OFS=25 clamps -> first sample 32768.
5. STOP: STOP asserted mid-run -> no DONE, LUT_VALUE holds; START+STOP in the same cycle -> channel stays IDLE; START during RUN -> index sequence unaffected.
6. Reset/enable: RST pulsed asynchronously between clock edges mid-run -> all outputs 0 immediately; EN deasserted mid-run -> BUSY=0 next cycle, no VALID, LUT_VALUE held.
